// File: rtl/lcd_bus_reader.sv
// lcd_bus_reader: read-side engine for the HD44780 16x2 character-LCD bus.
// Runs RW=1 read cycles for either the busy flag/address counter (RS=0) or a
// DDRAM/CGRAM data byte (RS=1). Poll mode repeats busy-flag reads until BF=0.
// Define LCD_RD_TIMEOUT_EN to bound poll mode at MAX_POLLS reads and report
// oTimeout; without it polling is unbounded and oTimeout is tied low.
module lcd_bus_reader #(
    parameter int T_SETUP   = 3,
    parameter int T_EN_HIGH = 25,
    parameter int T_HOLD    = 2
`ifdef LCD_RD_TIMEOUT_EN
    , parameter int MAX_POLLS = 1024
`endif
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iStart,
    input  logic       iRS,
    input  logic       iPoll,
    output logic       oDone,
    output logic [7:0] oDATA,
    output logic       oBF,
    output logic       oTimeout,
    output logic       oActive,
    inout  wire  [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
);

    localparam int T_MAX_SH = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
    localparam int T_MAX    = (T_EN_HIGH > T_MAX_SH) ? T_EN_HIGH : T_MAX_SH;
    localparam int CNT_W    = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EN_HI,
        HOLD,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic             poll_q, poll_d;
    logic [7:0]       data_q, data_d;
    logic             bf_q, bf_d;
    logic             done_q, done_d;
    logic             active_q, active_d;
    logic             rw_q, rw_d;
    logic             en_q, en_d;
    logic             rsPin_q, rsPin_d;

`ifdef LCD_RD_TIMEOUT_EN
    localparam int POLL_W = $clog2(MAX_POLLS + 1);
    logic [POLL_W-1:0] polls_q, polls_d;
    logic              timeout_q, timeout_d;
`endif

    // The LCD owns the data bus during reads; this block only ever listens.
    assign LCD_DATA = 8'hzz;

    // Next-state logic: phase sequencing, request capture and data sampling.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        poll_d  = poll_q;
        data_d  = data_q;
        bf_d    = bf_q;
`ifdef LCD_RD_TIMEOUT_EN
        polls_d   = polls_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (iStart) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    rs_d    = iRS & ~iPoll;
                    poll_d  = iPoll;
`ifdef LCD_RD_TIMEOUT_EN
                    polls_d   = '0;
                    timeout_d = 1'b0;
`endif
                end
            end
            SETUP: begin
                if (cnt_q == CNT_W'(T_SETUP - 1)) begin
                    state_d = EN_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EN_HI: begin
                if (cnt_q == CNT_W'(T_EN_HIGH - 1)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    data_d  = LCD_DATA;
                    bf_d    = rs_q ? 1'b0 : LCD_DATA[7];
`ifdef LCD_RD_TIMEOUT_EN
                    polls_d = (polls_q == POLL_W'(MAX_POLLS)) ? polls_q : polls_q + 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == CNT_W'(T_HOLD - 1)) begin
                    cnt_d = '0;
                    if (poll_q && bf_q) begin
`ifdef LCD_RD_TIMEOUT_EN
                        if (polls_q >= POLL_W'(MAX_POLLS)) begin
                            state_d   = DONE;
                            timeout_d = 1'b1;
                        end else begin
                            state_d = SETUP;
                        end
`else
                        state_d = SETUP;
`endif
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        active_d = (state_d != IDLE);
        done_d   = (state_d == DONE);
        rw_d     = (state_d == SETUP) || (state_d == EN_HI) || (state_d == HOLD);
        en_d     = (state_d == EN_HI);
        rsPin_d  = rw_d & rs_d;
    end

    // State and output registers; bus pins come straight from flops so they never glitch.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rs_q     <= 1'b0;
            poll_q   <= 1'b0;
            data_q   <= 8'h00;
            bf_q     <= 1'b0;
            done_q   <= 1'b0;
            active_q <= 1'b0;
            rw_q     <= 1'b0;
            en_q     <= 1'b0;
            rsPin_q  <= 1'b0;
`ifdef LCD_RD_TIMEOUT_EN
            polls_q   <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rs_q     <= rs_d;
            poll_q   <= poll_d;
            data_q   <= data_d;
            bf_q     <= bf_d;
            done_q   <= done_d;
            active_q <= active_d;
            rw_q     <= rw_d;
            en_q     <= en_d;
            rsPin_q  <= rsPin_d;
`ifdef LCD_RD_TIMEOUT_EN
            polls_q   <= polls_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign oDone   = done_q;
    assign oDATA   = data_q;
    assign oBF     = bf_q;
    assign oActive = active_q;
    assign LCD_RW  = rw_q;
    assign LCD_EN  = en_q;
    assign LCD_RS  = rsPin_q;

`ifdef LCD_RD_TIMEOUT_EN
    assign oTimeout = timeout_q;
`else
    assign oTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_bus_reader.sv
// tb_lcd_bus_reader: table-driven bench for lcd_bus_reader with a small HD44780
// read model (returns 8'h80 for the first busyReads reads, then readyByte).
module tb_lcd_bus_reader;

    logic       iCLK = 1'b0;
    logic       iRST;
    logic       iStart;
    logic       iRS;
    logic       iPoll;
    logic       oDone;
    logic [7:0] oDATA;
    logic       oBF;
    logic       oTimeout;
    logic       oActive;
    wire  [7:0] lcdData;
    logic       LCD_RW;
    logic       LCD_EN;
    logic       LCD_RS;

    int         total = 0;
    int         bad = 0;

    int         readCount = 0;
    int         readBase = 0;
    int         busyReads = 0;
    logic [7:0] readyByte = 8'h00;
    logic [7:0] modelByte;
    logic       prevEnModel = 1'b0;

    typedef struct {
        string      name;
        logic       rs;
        logic       poll;
        int         busy;
        logic [7:0] ready;
        logic [7:0] expData;
        logic       expBf;
        logic       expTimeout;
        logic       expRs;
        int         expPulses;
        int         expLatency;
    } vec_t;

    vec_t vecs[$];

`ifdef LCD_RD_TIMEOUT_EN
    lcd_bus_reader #(.MAX_POLLS(4)) dut (
`else
    lcd_bus_reader dut (
`endif
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iStart   (iStart),
        .iRS      (iRS),
        .iPoll    (iPoll),
        .oDone    (oDone),
        .oDATA    (oDATA),
        .oBF      (oBF),
        .oTimeout (oTimeout),
        .oActive  (oActive),
        .LCD_DATA (lcdData),
        .LCD_RW   (LCD_RW),
        .LCD_EN   (LCD_EN),
        .LCD_RS   (LCD_RS)
    );

    always #10 iCLK = ~iCLK;

    // LCD model: drives the bus while RW=1, advancing to the next reply after each EN pulse.
    assign modelByte = ((readCount - readBase) < busyReads) ? 8'h80 : readyByte;
    assign lcdData   = LCD_RW ? modelByte : 8'hzz;

    always @(negedge iCLK) begin
        if (prevEnModel && !LCD_EN) readCount = readCount + 1;
        prevEnModel = LCD_EN;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total = total + 1;
        if (actual != expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, actual, actual, expected, expected);
        end
    endtask

    // Runs one transaction and checks latency, EN timing, protocol and results.
    task automatic applyStimulus(input vec_t v);
        int   cyc = 0;
        int   doneCyc = 0;
        int   pulses = 0;
        int   enCycles = 0;
        int   rsBad = 0;
        int   protoBad = 0;
        int   rwRun = 0;
        logic prevEn = 1'b0;
        logic prevRw = 1'b0;
        logic prevRs = 1'b0;
        @(negedge iCLK);
        readBase  = readCount;
        busyReads = v.busy;
        readyByte = v.ready;
        iStart    = 1'b1;
        iRS       = v.rs;
        iPoll     = v.poll;
        @(posedge iCLK);
        while (doneCyc == 0 && cyc < 5000) begin
            @(negedge iCLK);
            cyc = cyc + 1;
            if (cyc == 1) iStart = 1'b0;
            if (LCD_EN && !prevEn) begin
                pulses = pulses + 1;
                if (rwRun < 3) protoBad = protoBad + 1;
            end
            if (LCD_EN) enCycles = enCycles + 1;
            if (LCD_EN && !LCD_RW) protoBad = protoBad + 1;
            if (LCD_EN && prevEn && (LCD_RW != prevRw || LCD_RS != prevRs)) protoBad = protoBad + 1;
            if (LCD_RW && LCD_RS != v.expRs) rsBad = rsBad + 1;
            if (!oActive) protoBad = protoBad + 1;
            if (oDone && (LCD_RW || LCD_EN || LCD_RS)) protoBad = protoBad + 1;
            if (LCD_RW) rwRun = rwRun + 1;
            else rwRun = 0;
            if (oDone) doneCyc = cyc;
            prevEn = LCD_EN;
            prevRw = LCD_RW;
            prevRs = LCD_RS;
        end
        checkOutput({v.name, " latency"}, doneCyc, v.expLatency);
        checkOutput({v.name, " en pulses"}, pulses, v.expPulses);
        checkOutput({v.name, " en high cycles"}, enCycles, 25 * v.expPulses);
        checkOutput({v.name, " rs pin"}, rsBad, 0);
        checkOutput({v.name, " protocol"}, protoBad, 0);
        checkOutput({v.name, " oDATA"}, int'(oDATA), int'(v.expData));
        checkOutput({v.name, " oBF"}, int'(oBF), int'(v.expBf));
        checkOutput({v.name, " oTimeout"}, int'(oTimeout), int'(v.expTimeout));
    endtask

    initial begin
        int   doneA;
        int   doneB;
        int   cyc;
        int   errs;
        logic idleGap;

        vecs.push_back('{"bf read",       1'b0, 1'b0, 0,    8'h45, 8'h45, 1'b0, 1'b0, 1'b0, 1, 31});
        vecs.push_back('{"data read",     1'b1, 1'b0, 0,    8'h52, 8'h52, 1'b0, 1'b0, 1'b1, 1, 31});
        vecs.push_back('{"poll 3 busy",   1'b0, 1'b1, 3,    8'h07, 8'h07, 1'b0, 1'b0, 1'b0, 4, 121});
        vecs.push_back('{"bf busy once",  1'b0, 1'b0, 1,    8'h07, 8'h80, 1'b1, 1'b0, 1'b0, 1, 31});
        vecs.push_back('{"data clrs bf",  1'b1, 1'b0, 1,    8'h07, 8'h80, 1'b0, 1'b0, 1'b1, 1, 31});
        vecs.push_back('{"poll forces rs",1'b1, 1'b1, 2,    8'h07, 8'h07, 1'b0, 1'b0, 1'b0, 3, 91});
`ifdef LCD_RD_TIMEOUT_EN
        vecs.push_back('{"poll timeout",  1'b0, 1'b1, 1000, 8'h07, 8'h80, 1'b1, 1'b1, 1'b0, 4, 121});
        vecs.push_back('{"timeout clrd",  1'b1, 1'b0, 0,    8'h52, 8'h52, 1'b0, 1'b0, 1'b1, 1, 31});
`else
        vecs.push_back('{"poll unbounded",1'b0, 1'b1, 6,    8'h07, 8'h07, 1'b0, 1'b0, 1'b0, 7, 211});
`endif

        iRST   = 1'b1;
        iStart = 1'b0;
        iRS    = 1'b0;
        iPoll  = 1'b0;
        repeat (3) @(negedge iCLK);
        checkOutput("reset oDone", int'(oDone), 0);
        checkOutput("reset oDATA", int'(oDATA), 0);
        checkOutput("reset oBF", int'(oBF), 0);
        checkOutput("reset oTimeout", int'(oTimeout), 0);
        checkOutput("reset oActive", int'(oActive), 0);
        checkOutput("reset bus pins", int'({LCD_RW, LCD_EN, LCD_RS}), 0);
        iRST = 1'b0;

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Reset in the middle of EN_HI: bus drops on the next edge and no oDone follows.
        @(negedge iCLK);
        readBase  = readCount;
        busyReads = 0;
        readyByte = 8'h45;
        iStart    = 1'b1;
        iRS       = 1'b0;
        iPoll     = 1'b0;
        @(posedge iCLK);
        @(negedge iCLK);
        iStart = 1'b0;
        repeat (10) @(negedge iCLK);
        checkOutput("mid reset en before", int'(LCD_EN), 1);
        iRST = 1'b1;
        @(posedge iCLK);
        #1;
        checkOutput("mid reset bus pins", int'({LCD_RW, LCD_EN, LCD_RS}), 0);
        checkOutput("mid reset oDone", int'(oDone), 0);
        checkOutput("mid reset oActive", int'(oActive), 0);
        checkOutput("mid reset oDATA", int'(oDATA), 0);
        @(negedge iCLK);
        iRST = 1'b0;
        errs = 0;
        repeat (5) begin
            @(negedge iCLK);
            if (oDone || oActive) errs = errs + 1;
        end
        checkOutput("post reset quiet", errs, 0);
        applyStimulus(vecs[0]);

        // iStart raised only during the DONE cycle must be ignored.
        @(negedge iCLK);
        readBase  = readCount;
        busyReads = 0;
        readyByte = 8'h45;
        iStart    = 1'b1;
        iRS       = 1'b0;
        iPoll     = 1'b0;
        @(posedge iCLK);
        @(negedge iCLK);
        iStart = 1'b0;
        cyc = 0;
        while (!oDone && cyc < 200) begin
            @(negedge iCLK);
            cyc = cyc + 1;
        end
        checkOutput("done seen", int'(oDone), 1);
        iStart = 1'b1;
        @(negedge iCLK);
        iStart = 1'b0;
        errs = 0;
        repeat (4) begin
            if (oActive || LCD_RW) errs = errs + 1;
            @(negedge iCLK);
        end
        checkOutput("start in DONE ignored", errs, 0);

        // iStart held high: one IDLE cycle, then a second transaction back to back.
        readBase  = readCount;
        readyByte = 8'h45;
        iStart    = 1'b1;
        @(posedge iCLK);
        cyc     = 0;
        doneA   = 0;
        doneB   = 0;
        idleGap = 1'b0;
        while (doneB == 0 && cyc < 300) begin
            @(negedge iCLK);
            cyc = cyc + 1;
            if (cyc == 32 && !oActive) idleGap = 1'b1;
            if (oDone && doneA == 0) doneA = cyc;
            else if (oDone) doneB = cyc;
        end
        iStart = 1'b0;
        checkOutput("b2b first done", doneA, 31);
        checkOutput("b2b idle gap", int'(idleGap), 1);
        checkOutput("b2b second done", doneB, 63);
        checkOutput("b2b oDATA", int'(oDATA), 'h45);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
